// File: rtl/text_render_pkg.sv
// Shared types and helpers for the pipelined text-mode renderer:
// cell-word field offsets, the pipeline record, palette reset values and font bitmaps.
package text_render_pkg;

  localparam int COORD_W = 10;
  localparam int PAL_N   = 16;

  function automatic int f_invert(input int code_w);
    return code_w;
  endfunction

  function automatic int f_blink(input int code_w);
    return code_w + 1;
  endfunction

  function automatic int f_fg_lo(input int code_w);
    return code_w + 2;
  endfunction

  function automatic int f_bg_lo(input int code_w);
    return code_w + 6;
  endfunction

  typedef struct packed {
    logic [COORD_W-1:0] col_off;
    logic [COORD_W-1:0] row_off;
    logic [COORD_W-1:0] cell_col;
    logic [COORD_W-1:0] cell_row;
    logic               in_range;
    logic               vde;
    logic               hs;
    logic               vs;
  } pipe_rec_t;

  // Idle record: blanked video with both syncs inactive (high).
  localparam pipe_rec_t REC_IDLE = '{col_off: '0, row_off: '0, cell_col: '0, cell_row: '0,
                                     in_range: 1'b0, vde: 1'b0, hs: 1'b1, vs: 1'b1};

  // Grey ramp {i,i,i}; wider channels pad zeros below i, narrower ones keep its top bits.
  function automatic logic [47:0] pal_reset_val(input int idx, input int cw);
    logic [15:0] ch;
    if (cw >= 4) ch = 16'(idx) << (cw - 4);
    else         ch = 16'(idx) >> (4 - cw);
    return (48'(ch) << (2 * cw)) | (48'(ch) << cw) | 48'(ch);
  endfunction

  // 8x16 master bitmaps, MSB = leftmost pixel; the ROM rescales them to the glyph size.
  function automatic logic [7:0] font_row8(input int code, input int row);
    logic [7:0] bits;
    bits = 8'h00;
    if (code == 'h7F) begin
      bits = 8'hFF;
    end else if (code == 'h41) begin
      case (row)
        2:                  bits = 8'h10;
        3:                  bits = 8'h38;
        4:                  bits = 8'h6C;
        5, 6, 8, 9, 10, 11: bits = 8'hC6;
        7:                  bits = 8'hFE;
        default:            bits = 8'h00;
      endcase
    end
    return bits;
  endfunction

endpackage

// File: rtl/text_render_pipe_font_rom.sv
// Synchronous font ROM: address {code,row}, one registered row of GLYPH_W pixels out.
module font_rom_sync
  import text_render_pkg::*;
#(
  parameter int CODE_W  = 7,
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 16,
  localparam int GH_LOG = $clog2(GLYPH_H),
  localparam int AW     = CODE_W + GH_LOG
) (
  input  logic               pixel_clk,
  input  logic               pixel_aresetn,
  input  logic [AW-1:0]      addr,
  output logic [GLYPH_W-1:0] row
);

  logic [7:0]         base;
  logic [GLYPH_W-1:0] row_bits;

  always_comb begin
    row_bits = '0;
    base = font_row8(int'(addr[AW-1:GH_LOG]), (int'(addr[GH_LOG-1:0]) * 16) / GLYPH_H);
    for (int i = 0; i < GLYPH_W; i++)
      row_bits[i] = base[3'(7 - (((GLYPH_W - 1 - i) * 8) / GLYPH_W))];
  end

  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) row <= '0;
    else                row <= row_bits;
  end

endmodule

// File: rtl/text_render_pipe.sv
// Pipelined text-mode renderer: VRAM cell fetch, font lookup, attributes, cursor, palette.
// RGB and syncs leave VRAM_LAT+2 cycles after the scan coordinates enter.
module text_render_pipe
  import text_render_pkg::*;
#(
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CODE_W       = 7,
  parameter int VRAM_LAT     = 1,
  parameter int BLINK_FRAMES = 32,
  parameter int COLOR_W      = 4
) (
  input  logic                            pixel_clk,
  input  logic                            pixel_aresetn,
  input  logic [9:0]                      draw_x,
  input  logic [9:0]                      draw_y,
  input  logic                            vde_in,
  input  logic                            hs_in,
  input  logic                            vs_in,
  output logic [$clog2(COLS*ROWS)-1:0]    cell_addr,
  input  logic [CODE_W+9:0]               cell_data,
  input  logic [6:0]                      cursor_x,
  input  logic [4:0]                      cursor_y,
  input  logic                            cursor_en,
  input  logic                            pal_we,
  input  logic [3:0]                      pal_addr,
  input  logic [3*COLOR_W-1:0]            pal_data,
  output logic [COLOR_W-1:0]              red,
  output logic [COLOR_W-1:0]              green,
  output logic [COLOR_W-1:0]              blue,
  output logic                            vde_out,
  output logic                            hs_out,
  output logic                            vs_out
);

  localparam int ADDR_W  = $clog2(COLS * ROWS);
  localparam int GW_LOG  = $clog2(GLYPH_W);
  localparam int GH_LOG  = $clog2(GLYPH_H);
  localparam int ROM_AW  = CODE_W + GH_LOG;
  localparam int FC_W    = $clog2(BLINK_FRAMES);
  localparam int RGB_W   = 3 * COLOR_W;
  localparam int X_MAX   = COLS * GLYPH_W;
  localparam int Y_MAX   = ROWS * GLYPH_H;
  localparam int INV_B   = f_invert(CODE_W);
  localparam int BLINK_B = f_blink(CODE_W);
  localparam int FG_LO   = f_fg_lo(CODE_W);
  localparam int BG_LO   = f_bg_lo(CODE_W);

  // ---- Stage A: cell address out, scan context delayed to meet cell_data
  logic [COORD_W-1:0] col_idx, row_idx;
  pipe_rec_t          rec_in;
  pipe_rec_t          rec_p0 [VRAM_LAT];

  assign col_idx   = draw_x >> GW_LOG;
  assign row_idx   = draw_y >> GH_LOG;
  assign cell_addr = ADDR_W'(32'(row_idx) * COLS + 32'(col_idx));

  always_comb begin
    rec_in = '{col_off:  draw_x & COORD_W'(GLYPH_W - 1),
               row_off:  draw_y & COORD_W'(GLYPH_H - 1),
               cell_col: col_idx,
               cell_row: row_idx,
               in_range: ({22'b0, draw_x} < 32'(X_MAX)) && ({22'b0, draw_y} < 32'(Y_MAX)),
               vde:      vde_in,
               hs:       hs_in,
               vs:       vs_in};
  end

  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      for (int i = 0; i < VRAM_LAT; i++) rec_p0[i] <= REC_IDLE;
    end else begin
      rec_p0[0] <= rec_in;
      for (int i = 1; i < VRAM_LAT; i++) rec_p0[i] <= rec_p0[i-1];
    end
  end

  // ---- Stage B: font ROM read, cell attributes registered alongside
  pipe_rec_t          rec_a, rec_p1;
  logic [ROM_AW-1:0]  rom_addr;
  logic [GLYPH_W-1:0] rom_row_p1;
  logic               inv_p1, blink_p1;
  logic [3:0]         fg_p1, bg_p1;

  assign rec_a    = rec_p0[VRAM_LAT-1];
  assign rom_addr = {cell_data[CODE_W-1:0], rec_a.row_off[GH_LOG-1:0]};

  font_rom_sync #(
    .CODE_W  (CODE_W),
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H)
  ) u_font_rom (
    .pixel_clk     (pixel_clk),
    .pixel_aresetn (pixel_aresetn),
    .addr          (rom_addr),
    .row           (rom_row_p1)
  );

  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      rec_p1   <= REC_IDLE;
      inv_p1   <= 1'b0;
      blink_p1 <= 1'b0;
      fg_p1    <= '0;
      bg_p1    <= '0;
    end else begin
      rec_p1   <= rec_a;
      inv_p1   <= cell_data[INV_B];
      blink_p1 <= cell_data[BLINK_B];
      fg_p1    <= cell_data[FG_LO +: 4];
      bg_p1    <= cell_data[BG_LO +: 4];
    end
  end

  // Frame counter advances on each vsync assertion; its MSB is the blink phase.
  logic            vs_d;
  logic [FC_W-1:0] frame_cnt;
  logic            blink_phase;

  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      vs_d      <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vs_d <= vs_in;
      if (vs_d && !vs_in) frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

  assign blink_phase = frame_cnt[FC_W-1];

  logic [RGB_W-1:0] pal_q [PAL_N];

  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= RGB_W'(pal_reset_val(i, COLOR_W));
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  // ---- Stage C: pixel decision, palette lookup, output register
  logic [GW_LOG-1:0] bit_idx;
  logic              pix, cur_hit;
  logic [3:0]        pal_idx;
  logic [RGB_W-1:0]  rgb_nxt;

  assign bit_idx = GW_LOG'(GLYPH_W - 1 - int'(rec_p1.col_off));
  assign pix     = rom_row_p1[bit_idx];
  assign cur_hit = cursor_en && !blink_phase
                && (rec_p1.cell_col == COORD_W'(cursor_x))
                && (rec_p1.cell_row == COORD_W'(cursor_y))
                && (rec_p1.row_off >= COORD_W'(GLYPH_H - 2));

  always_comb begin
    pal_idx = bg_p1;
    if (cur_hit)                      pal_idx = fg_p1;
    else if (blink_p1 && blink_phase) pal_idx = inv_p1 ? fg_p1 : bg_p1;
    else if (pix ^ inv_p1)            pal_idx = fg_p1;
    rgb_nxt = (rec_p1.vde && rec_p1.in_range) ? pal_q[pal_idx] : '0;
  end

  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      vde_out <= 1'b0;
      hs_out  <= 1'b1;
      vs_out  <= 1'b1;
    end else begin
      red     <= rgb_nxt[RGB_W-1 -: COLOR_W];
      green   <= rgb_nxt[2*COLOR_W-1 -: COLOR_W];
      blue    <= rgb_nxt[COLOR_W-1:0];
      vde_out <= rec_p1.vde;
      hs_out  <= rec_p1.hs;
      vs_out  <= rec_p1.vs;
    end
  end

endmodule
